tick_countdown: RTL and testbench

Programmable countdown timer driven by the slow divided clock from the clock divider stage. It synchronises the divider's `clkA` output into the `clk` domain, converts each rising edge into a one-cycle tick, and decrements a loadable count once per tick. On expiry it raises a one-cycle `done` strobe and a held `expired` flag, which the game and display control logic consumes.

---
 rtl/tick_pkg.sv | 25 ++
 rtl/sync_edge_detect.sv | 43 ++++
 rtl/tick_countdown.sv | 143 ++++++++++++++
 tb/tb_tick_countdown.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared types and constants for the countdown timer and its tick front end.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tick_pkg;

  // Default count width when the parent does not override it.
  localparam int TICK_W_DEFAULT = 16;

  // Fewer than two synchroniser flops is not metastability-safe.
  localparam int SYNC_STAGES_MIN = 2;

  // Countdown controller states; encoding is visible on debug taps.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp a requested synchroniser depth to the safe minimum.
  function automatic int sync_depth(input int requested);
    return (requested < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : requested;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises a slow level into clk and flags each rising edge as a one-cycle pulse.
// Latency: rise is high from SYNC_STAGES-1 to SYNC_STAGES edges after d is first sampled high.
// Backpressure: none; every clean rising edge produces exactly one pulse, falling edges none.
module sync_edge_detect
  import tick_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  // Depth actually built; a request below the safe minimum is rounded up.
  localparam int NS = sync_depth(SYNC_STAGES);

  logic [NS-1:0] sync_q;
  logic [NS-1:0] sync_d;
  logic          edge_q;
  logic          edge_d;

  // Shift the raw level into the chain; the edge register remembers the last synced value.
  always_comb begin
    sync_d = {sync_q[NS-2:0], d};
    edge_d = sync_q[NS-1];
  end

  // Synchroniser and edge history, cleared immediately on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  // New synced value high while the previous one was low: a rising edge.
  assign rise = sync_q[NS-1] & ~edge_q;

endmodule

// File: rtl/tick_countdown.sv
// Loadable countdown timer decremented once per rising edge of a slow divided clock.
// Latency: count updates 2 edges after tick_in is first sampled high (SYNC_STAGES=2); done/expired 1 edge after expiry decision.
// Backpressure: none; ticks arriving while paused, gated by en, or coinciding with load/pause are dropped.
module tick_countdown
  import tick_pkg::*;
#(
  parameter int W           = TICK_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick_in,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         start,
  input  logic         pause,
  output logic [W-1:0] count,
  output logic         running,
  output logic         done,
  output logic         expired,
  output logic         tick_pulse
);

  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  // Front end: divided clock level in, one-cycle rising-edge pulse out.
  logic tick_rise;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .reset (reset),
    .d     (tick_in),
    .rise  (tick_rise)
  );

  // A tick only counts while the gate is open.
  logic tick_eff;
  assign tick_eff = tick_rise & en;

  state_t       state_q;
  state_t       state_d;
  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic         done_q;
  logic         done_d;
  logic         running_q;
  logic         running_d;
  logic         expired_q;
  logic         expired_d;

  // Next state and count; priority is load, then start, then pause, then tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;

    if (load) begin
      // Load wins over everything and discards any coincident tick.
      count_d = load_value;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count_q == ZERO) begin
              // Nothing to count: expire straight away.
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RUN;
            end
          end
        end

        RUN: begin
          if (pause) begin
            // Pause beats a coincident tick; the count is held as-is.
            state_d = PAUSE;
          end else if (tick_eff) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              count_d = ZERO;
              state_d = DONE;
              done_d  = 1'b1;
            end
            // count_q == 0 in RUN is unreachable; hold rather than wrap.
          end
        end

        PAUSE: begin
          // Ticks are ignored here; only dropping pause resumes.
          if (!pause) begin
            state_d = RUN;
          end
        end

        DONE: begin
          // Parked until load or reset; start has no effect.
          count_d = ZERO;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Output flags decoded from the upcoming state so they switch on the transition edge.
  always_comb begin
    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  // Controller state, count and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      count_q   <= ZERO;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      done_q    <= done_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign count      = count_q;
  assign running    = running_q;
  assign done       = done_q;
  assign expired    = expired_q;
  assign tick_pulse = tick_rise;

endmodule

// File: tb/tb_tick_countdown.sv
module tb_tick_countdown;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_in = 1'b0;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'd0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [15:0] count;
  logic        running;
  logic        done;
  logic        expired;
  logic        tick_pulse;

  int checks = 0;
  int errors = 0;

  tick_countdown #(.W(16), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .tick_in    (tick_in),
    .en         (en),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .count      (count),
    .running    (running),
    .done       (done),
    .expired    (expired),
    .tick_pulse (tick_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: timer behaviour from its rules, with the tick seen as
  // "tick_in sampled high two edges ago and low three edges ago".
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_state = M_IDLE;
  int m_count = 0;
  bit m_done = 0;
  bit m_pulse = 0;
  bit samp[$] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin : model_b
    bit rising;
    if (!rst_n) begin
      m_state = M_IDLE; m_count = 0; m_done = 0; m_pulse = 0;
      samp = '{1'b0, 1'b0, 1'b0};
    end else begin
      rising = samp[1] && !samp[2];
      m_done = 0;
      if (load) begin
        m_count = int'(load_value); m_state = M_IDLE;
      end else if (m_state == M_IDLE) begin
        if (start) begin
          if (m_count == 0) begin m_state = M_DONE; m_done = 1; end
          else m_state = M_RUN;
        end
      end else if (m_state == M_RUN) begin
        if (pause) m_state = M_PAUSE;
        else if (rising && en && m_count > 0) begin
          m_count = m_count - 1;
          if (m_count == 0) begin m_state = M_DONE; m_done = 1; end
        end
      end else if (m_state == M_PAUSE) begin
        if (!pause) m_state = M_RUN;
      end
      samp.push_front(tick_in);
      void'(samp.pop_back());
      m_pulse = samp[1] && !samp[2];
    end
  end

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full tick_in period; reports how many pulses and done strobes were seen.
  task automatic send_tick(input int half, output int pulses, output int dones);
    pulses = 0; dones = 0;
    tick_in = 1'b1;
    repeat (half) begin @(negedge clk); pulses += int'(tick_pulse); dones += int'(done); end
    tick_in = 1'b0;
    repeat (half) begin @(negedge clk); pulses += int'(tick_pulse); dones += int'(done); end
  endtask

  task automatic test_reset();
    int p, d;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL reset_expired: got %b expected 0", expired); end
    checks++; if (tick_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", tick_pulse); end
    rst_n = 1'b1;
    @(negedge clk);
    do_load(16'd5);
    do_start();
    send_tick(8, p, d);
    send_tick(8, p, d);
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL midrun_count: got %0d expected 3", count); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL midrun_running: got %b expected 1", running); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL async_reset_count: got %0d expected 0", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL async_reset_running: got %b expected 0", running); end
    checks++; if (done !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL async_reset_flags: got done=%b expired=%b expected 0 0", done, expired); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // From IDLE with count 0, start must expire at once.
    do_start();
    checks++; if (done !== 1'b1 || expired !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got done=%b expired=%b expected 1 1", done, expired); end
    do_load(16'd0);
    checks++; if (expired !== 1'b0) begin errors++; $display("FAIL load_clears_expired: got %b expected 0", expired); end
  endtask

  task automatic test_basic_countdown();
    int p, d, total_done;
    logic [15:0] exp16;
    do_load(16'd3);
    do_start();
    checks++; if (running !== 1'b1 || count !== 16'd3) begin errors++; $display("FAIL start_no_decrement: got running=%b count=%0d expected 1 3", running, count); end
    total_done = 0;
    for (int i = 0; i < 3; i++) begin
      send_tick(8, p, d);
      total_done += d;
      exp16 = 16'(2 - i);
      checks++; if (count !== exp16) begin errors++; $display("FAIL countdown_step%0d: got %0d expected %0d", i, count, exp16); end
      checks++; if (p !== 1) begin errors++; $display("FAIL pulses_per_tick%0d: got %0d expected 1", i, p); end
    end
    checks++; if (total_done !== 1) begin errors++; $display("FAIL done_once: got %0d strobes expected 1", total_done); end
    checks++; if (expired !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL expired_hold: got expired=%b running=%b expected 1 0", expired, running); end
    send_tick(8, p, d);
    checks++; if (count !== 16'd0 || d !== 0) begin errors++; $display("FAIL after_expiry: got count=%0d done_strobes=%0d expected 0 0", count, d); end
  endtask

  task automatic test_pause_en();
    int p, d, tot;
    do_load(16'd4);
    do_start();
    pause = 1'b1;
    @(negedge clk);
    tot = 0;
    repeat (3) begin send_tick(8, p, d); tot += p; end
    checks++; if (count !== 16'd4) begin errors++; $display("FAIL pause_hold_count: got %0d expected 4", count); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running: got %b expected 0", running); end
    checks++; if (tot !== 3) begin errors++; $display("FAIL pause_pulses: got %0d expected 3", tot); end
    pause = 1'b0;
    @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running: got %b expected 1", running); end
    en = 1'b0;
    repeat (2) send_tick(8, p, d);
    checks++; if (count !== 16'd4) begin errors++; $display("FAIL en_gate_count: got %0d expected 4", count); end
    en = 1'b1;
    send_tick(8, p, d);
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL en_open_count: got %0d expected 3", count); end
  endtask

  task automatic test_simultaneous();
    // Running at count 3: load lands on the tick edge.
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (tick_pulse !== 1'b1) begin errors++; $display("FAIL sim_load_pulse: got %b expected 1", tick_pulse); end
    load = 1'b1; load_value = 16'd9;
    @(negedge clk);
    load = 1'b0;
    checks++; if (count !== 16'd9 || running !== 1'b0 || expired !== 1'b0) begin errors++; $display("FAIL load_vs_tick: got count=%0d running=%b expired=%b expected 9 0 0", count, running, expired); end
    repeat (6) @(negedge clk);
    tick_in = 1'b0;
    repeat (8) @(negedge clk);
    do_start();
    tick_in = 1'b1;
    repeat (2) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    checks++; if (count !== 16'd9 || running !== 1'b0) begin errors++; $display("FAIL pause_vs_tick: got count=%0d running=%b expected 9 0", count, running); end
    repeat (6) @(negedge clk);
    tick_in = 1'b0;
    repeat (8) @(negedge clk);
    pause = 1'b0;
    @(negedge clk);
    checks++; if (count !== 16'd9 || running !== 1'b1) begin errors++; $display("FAIL pause_release: got count=%0d running=%b expected 9 1", count, running); end
  endtask

  task automatic test_boundary();
    int p, d;
    do_load(16'd0);
    do_start();
    checks++; if (done !== 1'b1 || expired !== 1'b1 || running !== 1'b0) begin errors++; $display("FAIL zero_start: got done=%b expired=%b running=%b expected 1 1 0", done, expired, running); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || expired !== 1'b1) begin errors++; $display("FAIL zero_start_next: got done=%b expired=%b expected 0 1", done, expired); end
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    checks++; if (count !== 16'd0 || expired !== 1'b1 || running !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL start_in_done: got count=%0d expired=%b running=%b done=%b expected 0 1 0 0", count, expired, running, done); end
    do_load(16'hFFFF);
    do_start();
    send_tick(8, p, d);
    checks++; if (count !== 16'hFFFE) begin errors++; $display("FAIL max_decrement: got %0d expected 65534", count); end
  endtask

  task automatic test_glitch();
    int p;
    en = 1'b0;
    tick_in = 1'b1;
    @(negedge clk);
    checks++; if (tick_pulse !== 1'b0) begin errors++; $display("FAIL pulse_edge_k: got %b expected 0", tick_pulse); end
    @(negedge clk);
    checks++; if (tick_pulse !== 1'b1) begin errors++; $display("FAIL pulse_edge_k1: got %b expected 1", tick_pulse); end
    @(negedge clk);
    checks++; if (tick_pulse !== 1'b0) begin errors++; $display("FAIL pulse_edge_k2: got %b expected 0", tick_pulse); end
    p = 0;
    repeat (17) begin @(negedge clk); p += int'(tick_pulse); end
    checks++; if (p !== 0) begin errors++; $display("FAIL long_high_pulses: got %0d expected 0", p); end
    tick_in = 1'b0;
    p = 0;
    repeat (10) begin @(negedge clk); p += int'(tick_pulse); end
    checks++; if (p !== 0) begin errors++; $display("FAIL falling_pulses: got %0d expected 0", p); end
    p = 0;
    for (int i = 0; i < 4; i++) begin
      tick_in = 1'b1;
      repeat ($urandom_range(3, 12)) begin @(negedge clk); p += int'(tick_pulse); end
      tick_in = 1'b0;
      repeat ($urandom_range(3, 12)) begin @(negedge clk); p += int'(tick_pulse); end
    end
    checks++; if (p !== 4) begin errors++; $display("FAIL random_edges_pulses: got %0d expected 4", p); end
    en = 1'b1;
  endtask

  task automatic test_random();
    int ph;
    ph = 4;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      checks++; if (count !== m_count[15:0]) begin errors++; $display("FAIL rnd_count c=%0d: got %0d expected %0d", c, count, m_count[15:0]); end
      checks++; if (running !== (m_state == M_RUN)) begin errors++; $display("FAIL rnd_running c=%0d: got %b expected %b", c, running, (m_state == M_RUN)); end
      checks++; if (expired !== (m_state == M_DONE)) begin errors++; $display("FAIL rnd_expired c=%0d: got %b expected %b", c, expired, (m_state == M_DONE)); end
      checks++; if (done !== m_done) begin errors++; $display("FAIL rnd_done c=%0d: got %b expected %b", c, done, m_done); end
      checks++; if (tick_pulse !== m_pulse) begin errors++; $display("FAIL rnd_pulse c=%0d: got %b expected %b", c, tick_pulse, m_pulse); end
      load = ($urandom_range(0, 29) == 0);
      load_value = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
      start = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      en = ($urandom_range(0, 7) != 0);
      ph--;
      if (ph == 0) begin tick_in = ~tick_in; ph = $urandom_range(3, 10); end
      if ($urandom_range(0, 699) == 0) begin #2 rst_n = 1'b0; #1 rst_n = 1'b1; end
    end
    load = 1'b0; start = 1'b0; pause = 1'b0; en = 1'b1; tick_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_countdown();
    test_pause_en();
    test_simultaneous();
    test_boundary();
    test_glitch();
    test_random();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
